// File: rtl/pet_pkg.sv
// rtl/pet_pkg.sv - shared opcode constants and FSM state encoding for the pet stats engine
package pet_pkg;

   typedef enum logic {
      AWAKE  = 1'b0,
      ASLEEP = 1'b1
   } pet_state_e;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_CARE   = 3'd1;
   localparam logic [2:0] OP_SLEEP  = 3'd2;
   localparam logic [2:0] OP_WAKE   = 3'd3;
   localparam logic [2:0] OP_REFILL = 3'd4;

endpackage

// File: rtl/pet_stats_engine_if.sv
// rtl/pet_stats_engine_if.sv - command handshake bundle between host and pet stats engine
interface pet_stats_engine_if;

   logic       cmd_valid;
   logic [7:0] cmd_data;
   logic       cmd_ready;

   modport master (output cmd_valid, output cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_data, output cmd_ready);

endinterface

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running 0..TICK_DIV-1 counter producing the decay tick
module tick_divider #(
   parameter int TICK_DIV = 10_000_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/pet_stats_engine.sv
// rtl/pet_stats_engine.sv - virtual pet stats with periodic decay, sleep/wake FSM and care commands
module pet_stats_engine
   import pet_pkg::*;
#(
   parameter int NUM_STATS  = 5,
   parameter int STAT_W     = 5,
   parameter int TICK_DIV   = 10_000_000,
   parameter int ENERGY_IDX = 3,
   parameter int CARE_STEP  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    rand_in,
   pet_stats_engine_if.slave             cmd,
   output logic [NUM_STATS*STAT_W-1:0]   stats,
   output logic                          is_sleeping,
   output logic                          tick,
   output logic                          alarm,
   output logic                          cmd_err
);

   localparam logic [STAT_W-1:0] STAT_MAX = '1;
   localparam logic [STAT_W:0]   CARE_INC = (STAT_W + 1)'(CARE_STEP);

   logic [NUM_STATS-1:0][STAT_W-1:0] stats_q, stats_d;
   pet_state_e                       state_q, state_d;
   logic                             alarm_q, alarm_d;
   logic                             err_q, err_d;
   logic                             accept;
   logic [2:0]                       opcode, idx;
   logic [STAT_W:0]                  care_sum;
   logic                             unused_bits;

   tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Decay owns the tick cycle, so commands are simply held off for that one cycle.
   assign cmd.cmd_ready = !tick;
   assign accept        = cmd.cmd_valid && !tick;
   assign opcode        = cmd.cmd_data[7:5];
   assign idx           = cmd.cmd_data[2:0];
   assign unused_bits   = ^{cmd.cmd_data[4:3], rand_in};

   always_comb begin
      stats_d  = stats_q;
      state_d  = state_q;
      err_d    = 1'b0;
      care_sum = '0;
      if (tick) begin
         if (state_q == AWAKE) begin
            for (int i = 0; i < NUM_STATS; i++) begin
               if ((i == ENERGY_IDX || rand_in[i]) && stats_q[i] != '0)
                  stats_d[i] = stats_q[i] - STAT_W'(1);
            end
            if (stats_d[ENERGY_IDX] == '0) state_d = ASLEEP;
         end else begin
            if (stats_q[ENERGY_IDX] != STAT_MAX)
               stats_d[ENERGY_IDX] = stats_q[ENERGY_IDX] + STAT_W'(1);
            if (stats_d[ENERGY_IDX] == STAT_MAX) state_d = AWAKE;
         end
      end else if (accept) begin
         case (opcode)
            OP_NOP: ;
            OP_CARE: begin
               if (state_q == ASLEEP || {1'b0, idx} >= 4'(NUM_STATS)) begin
                  err_d = 1'b1;
               end else begin
                  for (int i = 0; i < NUM_STATS; i++) begin
                     if (idx == 3'(i)) begin
                        care_sum   = {1'b0, stats_q[i]} + CARE_INC;
                        stats_d[i] = care_sum[STAT_W] ? STAT_MAX : care_sum[STAT_W-1:0];
                     end
                  end
               end
            end
            OP_SLEEP: begin
               if (state_q == ASLEEP) err_d = 1'b1;
               else                   state_d = ASLEEP;
            end
            OP_WAKE: begin
               if (state_q == AWAKE) err_d = 1'b1;
               else                  state_d = AWAKE;
            end
            OP_REFILL: begin
               if (state_q == ASLEEP) err_d = 1'b1;
               else                   stats_d = '1;
            end
            default: err_d = 1'b1;
         endcase
      end
   end

   // Built from the registered stats, so alarm trails a stat reaching zero by one cycle.
   always_comb begin
      alarm_d = 1'b0;
      for (int i = 0; i < NUM_STATS; i++) begin
         if (stats_q[i] == '0) alarm_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stats_q <= '1;
         state_q <= AWAKE;
         alarm_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         stats_q <= stats_d;
         state_q <= state_d;
         alarm_q <= alarm_d;
         err_q   <= err_d;
      end
   end

   assign stats       = stats_q;
   assign is_sleeping = (state_q == ASLEEP);
   assign alarm       = alarm_q;
   assign cmd_err     = err_q;

endmodule

// File: tb/tb_pet_stats_engine.sv
// tb/tb_pet_stats_engine.sv - directed scoreboard bench for pet_stats_engine
module tb_pet_stats_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rand_in;
   logic [24:0] stats;
   logic        is_sleeping, tick, alarm, cmd_err;

   pet_stats_engine_if cmd_if ();

   pet_stats_engine #(
      .NUM_STATS  (5),
      .STAT_W     (5),
      .TICK_DIV   (4),
      .ENERGY_IDX (3),
      .CARE_STEP  (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rand_in     (rand_in),
      .cmd         (cmd_if),
      .stats       (stats),
      .is_sleeping (is_sleeping),
      .tick        (tick),
      .alarm       (alarm),
      .cmd_err     (cmd_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;

   localparam logic [31:0] ALL31 = 32'h01FF_FFFF;

   function automatic logic [31:0] mk(input int s0, input int s1, input int s2, input int s3, input int s4);
      return 32'((s0 & 31) | ((s1 & 31) << 5) | ((s2 & 31) << 10) | ((s3 & 31) << 15) | ((s4 & 31) << 20));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic pop_cmp(input logic [31:0] obs);
      exp_t e;
      compared++;
      if (sb.size() == 0) begin
         mismatched++;
         $error("FAIL scoreboard_empty: observed %0h expected nothing", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      push(tag, exp);
      pop_cmp(obs);
   endtask

   task automatic send(input logic [7:0] data, input string tag, input logic [31:0] exp_stats, input logic exp_err);
      int guard = 0;
      while (tick && guard < 8) begin
         step();
         guard++;
      end
      chk({tag, "_ready"}, 32'(cmd_if.cmd_ready), 32'd1);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_data  = data;
      push({tag, "_stats"}, exp_stats);
      push({tag, "_err"}, 32'(exp_err));
      step();
      cmd_if.cmd_valid = 1'b0;
      pop_cmp(32'(stats));
      pop_cmp(32'(cmd_err));
   endtask

   task automatic align();
      do step(); while (cyc % 4 != 0);
   endtask

   initial begin
      int ticks;
      int guard;
      rst_n            = 1'b0;
      rand_in          = 8'h00;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stats", 32'(stats), ALL31);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_alarm", 32'(alarm), 32'd0);
      chk("rst_err", 32'(cmd_err), 32'd0);
      chk("rst_sleep", 32'(is_sleeping), 32'd0);

      rst_n = 1'b1;
      cyc   = 0;
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("tick_c%0d", c), 32'(tick), 32'((c == 3 || c == 7) ? 1 : 0));
         if (c == 0) chk("stats_c0", 32'(stats), ALL31);
         step();
      end
      chk("decay_quiet", 32'(stats), mk(31, 31, 31, 29, 31));

      send(8'h80, "refill", ALL31, 1'b0);

      rand_in = 8'hFF;
      ticks   = 0;
      guard   = 0;
      while (ticks < 31 && guard < 200) begin
         if (tick) ticks++;
         step();
         guard++;
      end
      chk("drain_ticks", 32'(ticks), 32'd31);
      chk("drain_stats", 32'(stats), 32'd0);
      chk("drain_sleep", 32'(is_sleeping), 32'd1);
      chk("alarm_lag", 32'(alarm), 32'd0);
      step();
      chk("alarm_high", 32'(alarm), 32'd1);
      align();
      chk("asleep_decay", 32'(stats), mk(0, 0, 0, 1, 0));
      chk("asleep_still", 32'(is_sleeping), 32'd1);

      send(8'h20, "care_asleep", mk(0, 0, 0, 1, 0), 1'b1);
      step();
      chk("err_one_cycle", 32'(cmd_err), 32'd0);
      send(8'h40, "sleep_asleep", mk(0, 0, 0, 1, 0), 1'b1);
      align();
      send(8'h80, "refill_asleep", mk(0, 0, 0, 2, 0), 1'b1);
      send(8'h00, "nop_asleep", mk(0, 0, 0, 2, 0), 1'b0);
      chk("nop_keeps_sleep", 32'(is_sleeping), 32'd1);
      align();
      send(8'h60, "wake", mk(0, 0, 0, 3, 0), 1'b0);
      chk("wake_state", 32'(is_sleeping), 32'd0);

      rand_in = 8'h00;
      send(8'h80, "refill2", ALL31, 1'b0);
      send(8'hE0, "op7", ALL31, 1'b1);
      step();
      chk("tick_after_op7", 32'(stats), mk(31, 31, 31, 30, 31));
      chk("alarm_clear", 32'(alarm), 32'd0);
      send(8'h26, "care_idx6", mk(31, 31, 31, 30, 31), 1'b1);
      send(8'h60, "wake_awake", mk(31, 31, 31, 30, 31), 1'b1);

      rand_in = 8'h01;
      align();
      align();
      chk("stat0_low", 32'(stats), mk(29, 31, 31, 28, 31));
      rand_in = 8'h00;
      send(8'h20, "care_sat", mk(31, 31, 31, 28, 31), 1'b0);
      align();
      send(8'h23, "care_energy", ALL31, 1'b0);

      step();
      step();
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_data  = 8'h40;
      chk("hold_tick", 32'(tick), 32'd1);
      chk("hold_not_ready", 32'(cmd_if.cmd_ready), 32'd0);
      step();
      chk("hold_ready", 32'(cmd_if.cmd_ready), 32'd1);
      chk("hold_not_taken", 32'(is_sleeping), 32'd0);
      chk("hold_decay", 32'(stats), mk(31, 31, 31, 30, 31));
      step();
      cmd_if.cmd_valid = 1'b0;
      chk("hold_taken", 32'(is_sleeping), 32'd1);
      chk("hold_no_err", 32'(cmd_err), 32'd0);

      step();
      chk("rest_energy30", 32'(stats), mk(31, 31, 31, 30, 31));
      step();
      chk("rest_tick", 32'(tick), 32'd1);
      step();
      chk("rest_energy31", 32'(stats), ALL31);
      chk("rest_woke", 32'(is_sleeping), 32'd0);

      step();
      rst_n = 1'b0;
      step();
      chk("midrst_tick", 32'(tick), 32'd0);
      chk("midrst_stats", 32'(stats), ALL31);
      rst_n = 1'b1;
      cyc   = 0;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("restart_tick_c%0d", c), 32'(tick), 32'((c == 3) ? 1 : 0));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
